// File: rtl/m68k_dtack_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : toaplan_bus_pkg
// Brief    : Shared types and wait-state defaults for the 68K DTACK controller.
// Revision : 1.0
// ============================================================================
package toaplan_bus_pkg;

  localparam int WS_CNT_W        = 8;
  localparam int FAST_WS_DEF     = 1;
  localparam int SHARED_WS_DEF   = 2;
  localparam int ROM_POST_WS_DEF = 0;
  localparam int TIMEOUT_DEF     = 255;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROM_WAIT = 3'd1,
    SH_WAIT  = 3'd2,
    COUNT    = 3'd3,
    ACK      = 3'd4,
    DRAIN    = 3'd5,
    TMO      = 3'd6
  } state_t;

  // Counter load value so that zero is reached on the last of n wait cycles.
  function automatic logic [WS_CNT_W-1:0] ws_load(input int n);
    if (n <= 1) return '0;
    if (n >= (1 << WS_CNT_W)) return WS_CNT_W'((1 << WS_CNT_W) - 2);
    return WS_CNT_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m68k_dtack_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : m68k_dtack_ctrl_if
// Brief     : 68K bus-cycle, SDRAM ROM and shared-RAM handshake signals.
// Revision  : 1.0
// ============================================================================
interface m68k_dtack_ctrl_if;

  logic cpu_as_n;
  logic cpu_rw;
  logic prog_rom_cs;
  logic shared_ram_cs;
  logic fast_cs;
  logic z80_busy;
  logic sdram_ack;
  logic sdram_req;
  logic shared_grant;
  logic cpu_dtack_n;
  logic cpu_berr_n;

  modport master (
    output cpu_as_n, cpu_rw, prog_rom_cs, shared_ram_cs, fast_cs, z80_busy, sdram_ack,
    input  sdram_req, shared_grant, cpu_dtack_n, cpu_berr_n
  );

  modport slave (
    input  cpu_as_n, cpu_rw, prog_rom_cs, shared_ram_cs, fast_cs, z80_busy, sdram_ack,
    output sdram_req, shared_grant, cpu_dtack_n, cpu_berr_n
  );

endinterface
`default_nettype wire

// File: rtl/m68k_dtack_ctrl_ws_counter.sv
`default_nettype none
// ============================================================================
// Module   : ws_counter
// Brief    : Saturating down-counter with load and zero flag for wait states.
// Revision : 1.0
// ============================================================================
module ws_counter
  import toaplan_bus_pkg::*;
(
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                load,
  input  logic [WS_CNT_W-1:0] load_val,
  input  logic                dec,
  output logic                zero
);

  logic [WS_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/m68k_dtack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : m68k_dtack_ctrl
// Brief    : 68K DTACK/BERR generation with per-region wait states, SDRAM ROM
//            handshake and Z80 shared-RAM arbitration.
//            Optional macro M68K_BERR_TIMEOUT_EN enables the bus-error timeout.
// Revision : 1.0
// ============================================================================
module m68k_dtack_ctrl
  import toaplan_bus_pkg::*;
#(
  parameter int FAST_WS     = FAST_WS_DEF,
  parameter int SHARED_WS   = SHARED_WS_DEF,
  parameter int ROM_POST_WS = ROM_POST_WS_DEF
`ifdef M68K_BERR_TIMEOUT_EN
  , parameter int TIMEOUT   = TIMEOUT_DEF
`endif
)(
  input  logic             clk_sys,
  input  logic             reset_n,
  m68k_dtack_ctrl_if.slave bus
);

  localparam logic [WS_CNT_W-1:0] c_FAST_LD   = ws_load(FAST_WS);
  localparam logic [WS_CNT_W-1:0] c_SHARED_LD = ws_load(SHARED_WS);
  localparam logic [WS_CNT_W-1:0] c_POST_LD   = ws_load(ROM_POST_WS);
`ifdef M68K_BERR_TIMEOUT_EN
  localparam logic [WS_CNT_W-1:0] c_TMO_LD    = ws_load(TIMEOUT);
`endif

  state_t              r_state, w_state_nxt;
  logic                r_sdram_req, w_req_nxt;
  logic                r_grant, w_grant_nxt;
  logic                r_ack_low, w_ack_low_nxt;
  logic                w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [WS_CNT_W-1:0] w_cnt_val;
  logic                w_ack_valid;
  logic                w_unused_rw;
`ifdef M68K_BERR_TIMEOUT_EN
  logic                r_berr_n, w_berr_n_nxt;
`endif

  // An ack counts only once it has been seen low since the request started.
  assign w_ack_valid = bus.sdram_ack && r_ack_low;
  assign w_unused_rw = bus.cpu_rw;

  ws_counter u_ws_counter (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .dec      (w_cnt_dec),
    .zero     (w_cnt_zero)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_sdram_req <= 1'b0;
      r_grant     <= 1'b0;
      r_ack_low   <= 1'b0;
`ifdef M68K_BERR_TIMEOUT_EN
      r_berr_n    <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_sdram_req <= w_req_nxt;
      r_grant     <= w_grant_nxt;
      r_ack_low   <= w_ack_low_nxt;
`ifdef M68K_BERR_TIMEOUT_EN
      r_berr_n    <= w_berr_n_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_req_nxt     = r_sdram_req;
    w_grant_nxt   = r_grant;
    w_ack_low_nxt = r_ack_low | ~bus.sdram_ack;
    w_cnt_load    = 1'b0;
    w_cnt_val     = '0;
    w_cnt_dec     = 1'b0;
`ifdef M68K_BERR_TIMEOUT_EN
    w_berr_n_nxt  = r_berr_n;
`endif
    case (r_state)
      IDLE: begin
        if (!bus.cpu_as_n) begin
          if (bus.prog_rom_cs) begin
            w_state_nxt   = ROM_WAIT;
            w_req_nxt     = 1'b1;
            w_ack_low_nxt = ~bus.sdram_ack;
`ifdef M68K_BERR_TIMEOUT_EN
            w_cnt_load    = 1'b1;
            w_cnt_val     = c_TMO_LD;
`endif
          end else if (bus.shared_ram_cs) begin
            w_state_nxt   = SH_WAIT;
`ifdef M68K_BERR_TIMEOUT_EN
            w_cnt_load    = 1'b1;
            w_cnt_val     = c_TMO_LD;
          end else if (!bus.fast_cs) begin
            w_state_nxt   = TMO;
            w_cnt_load    = 1'b1;
            w_cnt_val     = c_TMO_LD;
`endif
          end else begin
            // Unselected cycles land here too when no timeout exists.
            w_state_nxt   = (FAST_WS == 0) ? ACK : COUNT;
            w_cnt_load    = 1'b1;
            w_cnt_val     = c_FAST_LD;
          end
        end
      end
      ROM_WAIT: begin
        if (w_ack_valid) begin
          w_req_nxt = 1'b0;
          if (bus.cpu_as_n) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = (ROM_POST_WS == 0) ? ACK : COUNT;
            w_cnt_load  = 1'b1;
            w_cnt_val   = c_POST_LD;
          end
        end else if (bus.cpu_as_n) begin
          w_state_nxt = DRAIN;
`ifdef M68K_BERR_TIMEOUT_EN
        end else if (w_cnt_zero) begin
          w_state_nxt  = TMO;
          w_req_nxt    = 1'b0;
          w_berr_n_nxt = 1'b0;
        end else begin
          w_cnt_dec = 1'b1;
`endif
        end
      end
      DRAIN: begin
        if (w_ack_valid) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      SH_WAIT: begin
        if (bus.cpu_as_n) begin
          w_state_nxt = IDLE;
        end else if (!bus.z80_busy) begin
          w_grant_nxt = 1'b1;
          w_state_nxt = (SHARED_WS == 0) ? ACK : COUNT;
          w_cnt_load  = 1'b1;
          w_cnt_val   = c_SHARED_LD;
`ifdef M68K_BERR_TIMEOUT_EN
        end else if (w_cnt_zero) begin
          w_state_nxt  = TMO;
          w_berr_n_nxt = 1'b0;
        end else begin
          w_cnt_dec = 1'b1;
`endif
        end
      end
      COUNT: begin
        if (bus.cpu_as_n) begin
          w_state_nxt = IDLE;
        end else if (w_cnt_zero) begin
          w_state_nxt = ACK;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ACK: begin
        if (bus.cpu_as_n) w_state_nxt = IDLE;
      end
`ifdef M68K_BERR_TIMEOUT_EN
      TMO: begin
        if (bus.cpu_as_n) begin
          w_state_nxt = IDLE;
        end else if (r_berr_n) begin
          if (w_cnt_zero) w_berr_n_nxt = 1'b0;
          else            w_cnt_dec    = 1'b1;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
    if (w_state_nxt == IDLE) begin
      w_grant_nxt  = 1'b0;
`ifdef M68K_BERR_TIMEOUT_EN
      w_berr_n_nxt = 1'b1;
`endif
    end
  end

  assign bus.sdram_req    = r_sdram_req;
  assign bus.shared_grant = r_grant;
  assign bus.cpu_dtack_n  = (r_state != ACK);
`ifdef M68K_BERR_TIMEOUT_EN
  assign bus.cpu_berr_n   = r_berr_n;
`else
  assign bus.cpu_berr_n   = 1'b1;
`endif

endmodule
`default_nettype wire
